npc_seq_unit: RTL and testbench

- Sequential next-PC unit for the MIPS datapath: owns the PC register and computes the next fetch address from sequential, branch, jump and register-jump selections.
- Generalises the earlier combinational next-PC adder:
  - full MIPS branch-compare set evaluated internally;
  - stall hold;
  - optional architectural delay slot, with a pending-redirect buffer;
  - exception entry and eret, with an EPC register.
- Sits between the control unit / register file and instruction memory.

---
 rtl/npc_seq_unit_if.sv | 27 ++
 rtl/npc_seq_unit.sv | 116 +++++++++++
 tb/tb_npc_seq_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/npc_seq_unit_if.sv
// Bundle between control/register-file side and the next-PC unit.
// Inputs are sampled on the clk rising edge; pc/pending/epc are registered, link/br_taken are combinational.
interface npc_seq_unit_if;
  logic        stall;
  logic [2:0]  npc_sel;
  logic [2:0]  br_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [25:0] imm26;
  logic        exc;
  logic        eret;
  logic [31:0] pc;
  logic [31:0] link;
  logic        br_taken;
  logic        pending;
  logic [31:0] epc;

  modport master (
    output stall, npc_sel, br_op, rs_val, rt_val, imm26, exc, eret,
    input  pc, link, br_taken, pending, epc
  );

  modport slave (
    input  stall, npc_sel, br_op, rs_val, rt_val, imm26, exc, eret,
    output pc, link, br_taken, pending, epc
  );
endinterface

// File: rtl/npc_seq_unit.sv
// Sequential next-PC unit: owns the PC, evaluates branch compares, and handles
// stall, optional delay-slot redirect buffering, exception entry and eret.
module npc_seq_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          DELAY_SLOT = 0
) (
  input  logic          clk,
  input  logic          reset,
  npc_seq_unit_if.slave bus
);

  typedef enum logic {RUN = 1'b0, SLOT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tgt_q, tgt_d;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;
  logic        cmp_true;
  logic        rs_neg;
  logic        rs_zero;
  logic        redirect;

  assign pc4    = pc_q + 32'd4;
  assign br_tgt = pc4 + {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
  assign j_tgt  = {pc4[31:28], bus.imm26, 2'b00};
  assign rs_neg  = bus.rs_val[31];
  assign rs_zero = (bus.rs_val == 32'd0);

  always_comb begin
    cmp_true = 1'b0;
    case (bus.br_op)
      3'b000:  cmp_true = (bus.rs_val == bus.rt_val);
      3'b001:  cmp_true = (bus.rs_val != bus.rt_val);
      3'b010:  cmp_true = rs_neg || rs_zero;
      3'b011:  cmp_true = !rs_neg && !rs_zero;
      3'b100:  cmp_true = rs_neg;
      3'b101:  cmp_true = !rs_neg;
      default: cmp_true = 1'b0;
    endcase
  end

  assign bus.br_taken = (bus.npc_sel == 3'b001) && cmp_true;
  assign redirect     = bus.br_taken || (bus.npc_sel == 3'b010) || (bus.npc_sel == 3'b011);

  always_comb begin
    target = pc4;
    case (bus.npc_sel)
      3'b001:  target = br_tgt;
      3'b010:  target = j_tgt;
      3'b011:  target = bus.rs_val;
      default: target = pc4;
    endcase
  end

  // Priority: exc > eret > stall > buffered slot redirect > new redirect > sequential.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    tgt_d   = tgt_q;
    state_d = state_q;
    if (bus.exc) begin
      epc_d   = (state_q == SLOT) ? (pc_q - 32'd4) : pc_q;
      pc_d    = EXC_VEC;
      state_d = RUN;
    end else if (bus.eret) begin
      pc_d    = epc_q;
      state_d = RUN;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (state_q == SLOT) begin
      pc_d    = tgt_q;
      state_d = RUN;
    end else if (redirect) begin
      if (DELAY_SLOT != 0) begin
        pc_d    = pc4;
        tgt_d   = target;
        state_d = SLOT;
      end else begin
        pc_d = target;
      end
    end else begin
      pc_d = pc4;
    end
    // Without a delay slot the buffer never exists; constant-fold it away.
    if (DELAY_SLOT == 0) begin
      tgt_d   = 32'd0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      epc_q   <= 32'd0;
      tgt_q   <= 32'd0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tgt_q   <= tgt_d;
      state_q <= state_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.epc     = epc_q;
  assign bus.pending = (state_q == SLOT);
  assign bus.link    = (DELAY_SLOT != 0) ? (pc_q + 32'd8) : pc4;

endmodule

// File: tb/tb_npc_seq_unit.sv
// Directed bench for npc_seq_unit: one instance without and one with a delay slot,
// sharing clock and reset.
module tb_npc_seq_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  npc_seq_unit_if b0 ();
  npc_seq_unit_if b1 ();

  npc_seq_unit #(.DELAY_SLOT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  npc_seq_unit #(.DELAY_SLOT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [2:0] sel, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [25:0] imm);
    b0.npc_sel = sel; b0.br_op = op; b0.rs_val = rs; b0.rt_val = rt; b0.imm26 = imm;
    b0.stall = 1'b0; b0.exc = 1'b0; b0.eret = 1'b0;
  endtask

  task automatic drive1(input logic [2:0] sel, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [25:0] imm);
    b1.npc_sel = sel; b1.br_op = op; b1.rs_val = rs; b1.rt_val = rt; b1.imm26 = imm;
    b1.stall = 1'b0; b1.exc = 1'b0; b1.eret = 1'b0;
  endtask

  task automatic do_reset();
    drive0(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (b0.pc !== 32'h3000) begin errors++; $display("FAIL reset_pc0 got %h exp %h", b0.pc, 32'h3000); end
    checks++; if (b0.pending !== 1'b0) begin errors++; $display("FAIL reset_pending0 got %b exp 0", b0.pending); end
    checks++; if (b0.epc !== 32'h0) begin errors++; $display("FAIL reset_epc0 got %h exp 0", b0.epc); end
    checks++; if (b1.pc !== 32'h3000) begin errors++; $display("FAIL reset_pc1 got %h exp %h", b1.pc, 32'h3000); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL reset_pending1 got %b exp 0", b1.pending); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (b0.pc !== 32'h3000 + 32'(4 * i)) begin
        errors++; $display("FAIL seq_step%0d got %h exp %h", i, b0.pc, 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive0(3'b011, 3'b111, 32'hFFFF_FFFC, 32'd0, 26'd0);
    tick();
    checks++; if (b0.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h exp fffffffc", b0.pc); end
    drive0(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    tick();
    checks++; if (b0.pc !== 32'h0) begin errors++; $display("FAIL wrap got %h exp 0", b0.pc); end
  endtask

  task automatic test_branch();
    do_reset();
    drive0(3'b001, 3'b000, 32'd5, 32'd5, 26'h000FFFF);
    #1;
    checks++; if (b0.br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %b exp 1", b0.br_taken); end
    tick();
    checks++; if (b0.pc !== 32'h3000) begin errors++; $display("FAIL beq_pc got %h exp 3000", b0.pc); end

    do_reset();
    drive0(3'b001, 3'b001, 32'd5, 32'd5, 26'h000FFFF);
    #1;
    checks++; if (b0.br_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got %b exp 0", b0.br_taken); end
    tick();
    checks++; if (b0.pc !== 32'h3004) begin errors++; $display("FAIL bne_pc got %h exp 3004", b0.pc); end

    do_reset();
    drive0(3'b001, 3'b100, 32'h8000_0000, 32'd0, 26'h0000004);
    tick();
    checks++; if (b0.pc !== 32'h3014) begin errors++; $display("FAIL bltz_pc got %h exp 3014", b0.pc); end

    do_reset();
    drive0(3'b001, 3'b011, 32'd0, 32'd0, 26'h0000004);
    tick();
    checks++; if (b0.pc !== 32'h3004) begin errors++; $display("FAIL bgtz_pc got %h exp 3004", b0.pc); end

    do_reset();
    drive0(3'b001, 3'b010, 32'd0, 32'd0, 26'h0000004);
    tick();
    checks++; if (b0.pc !== 32'h3014) begin errors++; $display("FAIL blez_pc got %h exp 3014", b0.pc); end

    do_reset();
    drive0(3'b001, 3'b101, 32'hFFFF_FFFF, 32'd0, 26'h0000004);
    tick();
    checks++; if (b0.pc !== 32'h3004) begin errors++; $display("FAIL bgez_neg_pc got %h exp 3004", b0.pc); end
  endtask

  task automatic test_jump();
    do_reset();
    drive0(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C10);
    #1;
    checks++; if (b0.link !== 32'h3004) begin errors++; $display("FAIL link0 got %h exp 3004", b0.link); end
    tick();
    checks++; if (b0.pc !== 32'h3040) begin errors++; $display("FAIL j_pc got %h exp 3040", b0.pc); end
    drive0(3'b011, 3'b111, 32'h1234_5678, 32'd0, 26'd0);
    tick();
    checks++; if (b0.pc !== 32'h1234_5678) begin errors++; $display("FAIL jr_pc got %h exp 12345678", b0.pc); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    drive1(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C40);
    #1;
    checks++; if (b1.link !== 32'h3008) begin errors++; $display("FAIL link1 got %h exp 3008", b1.link); end
    tick();
    checks++; if (b1.pc !== 32'h3004) begin errors++; $display("FAIL ds_slot_pc got %h exp 3004", b1.pc); end
    checks++; if (b1.pending !== 1'b1) begin errors++; $display("FAIL ds_pending got %b exp 1", b1.pending); end
    drive1(3'b001, 3'b000, 32'd7, 32'd7, 26'h0000010);
    tick();
    checks++; if (b1.pc !== 32'h3100) begin errors++; $display("FAIL ds_target got %h exp 3100", b1.pc); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL ds_clear got %b exp 0", b1.pending); end
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    tick();
    checks++; if (b1.pc !== 32'h3104) begin errors++; $display("FAIL ds_after got %h exp 3104", b1.pc); end
  endtask

  task automatic test_stall();
    do_reset();
    drive1(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C40);
    tick();
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    b1.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b1.pc !== 32'h3004) begin errors++; $display("FAIL stall_pc%0d got %h exp 3004", i, b1.pc); end
      checks++; if (b1.pending !== 1'b1) begin errors++; $display("FAIL stall_pend%0d got %b exp 1", i, b1.pending); end
    end
    b1.stall = 1'b0;
    tick();
    checks++; if (b1.pc !== 32'h3100) begin errors++; $display("FAIL stall_release got %h exp 3100", b1.pc); end
  endtask

  task automatic test_exceptions();
    do_reset();
    repeat (4) tick();
    b0.exc = 1'b1; b0.stall = 1'b1;
    tick();
    checks++; if (b0.pc !== 32'h4180) begin errors++; $display("FAIL exc_pc got %h exp 4180", b0.pc); end
    checks++; if (b0.epc !== 32'h3010) begin errors++; $display("FAIL exc_epc got %h exp 3010", b0.epc); end
    drive0(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C40);
    b0.eret = 1'b1;
    tick();
    checks++; if (b0.pc !== 32'h3010) begin errors++; $display("FAIL eret_pc got %h exp 3010", b0.pc); end
    drive0(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    tick();
    b0.exc = 1'b1; b0.eret = 1'b1;
    tick();
    checks++; if (b0.pc !== 32'h4180) begin errors++; $display("FAIL exc_eret_pc got %h exp 4180", b0.pc); end
    checks++; if (b0.epc !== 32'h3014) begin errors++; $display("FAIL exc_eret_epc got %h exp 3014", b0.epc); end

    do_reset();
    drive1(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C40);
    tick();
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    b1.exc = 1'b1;
    tick();
    checks++; if (b1.epc !== 32'h3000) begin errors++; $display("FAIL slot_exc_epc got %h exp 3000", b1.epc); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL slot_exc_pend got %b exp 0", b1.pending); end
    checks++; if (b1.pc !== 32'h4180) begin errors++; $display("FAIL slot_exc_pc got %h exp 4180", b1.pc); end
    b1.exc = 1'b0; b1.eret = 1'b1;
    tick();
    checks++; if (b1.pc !== 32'h3000) begin errors++; $display("FAIL slot_eret_pc got %h exp 3000", b1.pc); end

    do_reset();
    drive1(3'b010, 3'b111, 32'd0, 32'd0, 26'h0000C40);
    tick();
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++; if (b1.pc !== 32'h3000) begin errors++; $display("FAIL rst_pend_pc got %h exp 3000", b1.pc); end
    checks++; if (b1.pending !== 1'b0) begin errors++; $display("FAIL rst_pend_pend got %b exp 0", b1.pending); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive0(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    drive1(3'b000, 3'b111, 32'd0, 32'd0, 26'd0);
    test_reset();
    test_wrap();
    test_branch();
    test_jump();
    test_delay_slot();
    test_stall();
    test_exceptions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
